seq_pattern_serializer: RTL and testbench



---
 rtl/seq_pattern_serializer.sv | 180 ++++++++++++++++++
 tb/tb_seq_pattern_serializer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_pattern_serializer                                       |
// | Description : Serial bit-pattern transmitter. Takes a pattern, a bit count |
// |               and a repeat count over a valid/ready load handshake, then   |
// |               shifts the pattern out MSB-first, one bit per clock, with    |
// |               back-to-back repetitions and a one-cycle done pulse.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_pattern_serializer #(
    parameter int WIDTH = 16,
    parameter int REP_W = 8,
    parameter int NB_W  = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [NB_W-1:0]  nbits,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    // Bit index only needs to address 0..WIDTH-1.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [NB_W-1:0]  c_WIDTH_NB  = NB_W'(WIDTH);
    localparam logic [IDX_W-1:0] c_LAST_FULL = IDX_W'(WIDTH - 1);

    // FSM state
    logic [1:0]       r_state;
    logic [1:0]       w_state_n;

    // Job datapath: captured pattern, index of the last bit of a pass,
    // current bit index and remaining extra passes
    logic [WIDTH-1:0] r_pat;
    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] r_idx;
    logic [REP_W-1:0] r_rep;
    logic [WIDTH-1:0] w_pat_n;
    logic [IDX_W-1:0] w_last_n;
    logic [IDX_W-1:0] w_idx_n;
    logic [REP_W-1:0] w_rep_n;

    // Registered outputs and their next values
    logic             r_x;
    logic             r_x_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_load_ready;
    logic             w_x_n;
    logic             w_x_valid_n;
    logic             w_busy_n;
    logic             w_done_n;
    logic             w_load_ready_n;

    // Effective bit count mapping: 0 or anything beyond WIDTH means a full-width pass
    logic             w_nb_full;
    logic [IDX_W-1:0] w_load_last;
    logic             w_accept;
    logic             w_pass_end;

    assign w_nb_full   = (nbits == '0) || (nbits > c_WIDTH_NB);
    assign w_load_last = w_nb_full ? c_LAST_FULL : IDX_W'(nbits - NB_W'(1));
    assign w_accept    = (r_state == c_ST_IDLE) && load_valid;
    assign w_pass_end  = (r_idx == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state logic; abort wins over the end-of-job transition
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (load_valid) begin
                    w_state_n = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (abort) begin
                    w_state_n = c_ST_IDLE;
                end else if (w_pass_end && (r_rep == '0)) begin
                    w_state_n = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_n = c_ST_IDLE;
            end
            default: begin
                w_state_n = c_ST_IDLE;
            end
        endcase
    end

    // Datapath next values: capture on accept, walk the index down, reload between passes
    always_comb begin
        w_pat_n  = r_pat;
        w_last_n = r_last;
        w_idx_n  = r_idx;
        w_rep_n  = r_rep;
        if (w_accept) begin
            w_pat_n  = pattern;
            w_last_n = w_load_last;
            w_idx_n  = w_load_last;
            w_rep_n  = reps;
        end else if ((r_state == c_ST_SHIFT) && !abort) begin
            if (!w_pass_end) begin
                w_idx_n = r_idx - IDX_W'(1);
            end else if (r_rep != '0) begin
                w_rep_n = r_rep - REP_W'(1);
                w_idx_n = r_last;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pat  <= '0;
            r_last <= '0;
            r_idx  <= '0;
            r_rep  <= '0;
        end else begin
            r_pat  <= w_pat_n;
            r_last <= w_last_n;
            r_idx  <= w_idx_n;
            r_rep  <= w_rep_n;
        end
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        w_x_valid_n    = (w_state_n == c_ST_SHIFT);
        w_busy_n       = (w_state_n == c_ST_SHIFT);
        w_done_n       = (w_state_n == c_ST_DONE);
        w_load_ready_n = (w_state_n == c_ST_IDLE);
        w_x_n          = w_x_valid_n & w_pat_n[w_idx_n];
    end

    // Output registers; reset leaves the block ready and silent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x          <= 1'b0;
            r_x_valid    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_x          <= w_x_n;
            r_x_valid    <= w_x_valid_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_load_ready <= w_load_ready_n;
        end
    end

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign load_ready = r_load_ready;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seq_pattern_serializer                                    |
// | Description : Self-checking bench for seq_pattern_serializer. Expected     |
// |               serial streams come from a queue built directly from the     |
// |               job parameters (N bits MSB-first, repeated reps+1 times).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seq_pattern_serializer;

    localparam int WIDTH = 16;
    localparam int REP_W = 8;
    localparam int NB_W  = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [NB_W-1:0]  nbits;
    logic [REP_W-1:0] reps;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    seq_pattern_serializer #(
        .WIDTH (WIDTH),
        .REP_W (REP_W)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .pattern    (pattern),
        .nbits      (nbits),
        .reps       (reps),
        .abort      (abort),
        .x          (x),
        .x_valid    (x_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_n(input logic [NB_W-1:0] nb);
        return ((nb == 0) || (int'(nb) > WIDTH)) ? WIDTH : int'(nb);
    endfunction

    // Called at a negedge with the block idle; returns at a negedge with it idle.
    // abort_at / reset_at give the stream position (0-based) to disturb, -1 for none.
    task automatic run_job(input logic [WIDTH-1:0] pat, input logic [NB_W-1:0] nb,
                           input logic [REP_W-1:0] rp, input int abort_at,
                           input bit busyload, input int reset_at);
        bit q[$];
        int n;
        n = eff_n(nb);
        for (int p = 0; p <= int'(rp); p++)
            for (int i = n - 1; i >= 0; i--)
                q.push_back(pat[i]);

        check("idle_ready", load_ready, 1);
        check("idle_busy", busy, 0);
        load_valid = 1'b1;
        pattern    = pat;
        nbits      = nb;
        reps       = rp;
        @(negedge clk);
        load_valid = 1'b0;
        pattern    = WIDTH'($urandom);
        nbits      = NB_W'($urandom);
        reps       = REP_W'($urandom);

        for (int i = 0; i < q.size(); i++) begin
            if (i > 0) @(negedge clk);
            check("bit_valid", x_valid, 1);
            check("bit_x", x, q[i]);
            check("bit_busy", busy, 1);
            check("bit_ready", load_ready, 0);
            check("bit_done", done, 0);
            if (busyload) begin
                load_valid = 1'($urandom_range(0, 1));
                pattern    = WIDTH'($urandom);
                nbits      = NB_W'($urandom);
                reps       = REP_W'($urandom);
            end
            if (i == reset_at) begin
                #2;
                reset = 1'b0;
                #1;
                check("rst_x", x, 0);
                check("rst_valid", x_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", load_ready, 1);
                check("rst_done", done, 0);
                @(negedge clk);
                load_valid = 1'b0;
                reset      = 1'b1;
                return;
            end
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort      = 1'b0;
                load_valid = 1'b0;
                check("abort_valid", x_valid, 0);
                check("abort_x", x, 0);
                check("abort_busy", busy, 0);
                check("abort_ready", load_ready, 1);
                check("abort_done", done, 0);
                return;
            end
        end

        @(negedge clk);
        load_valid = 1'b0;
        check("done_pulse", done, 1);
        check("done_valid", x_valid, 0);
        check("done_x", x, 0);
        check("done_busy", busy, 0);
        check("done_ready", load_ready, 0);
        @(negedge clk);
        check("post_done", done, 0);
        check("post_ready", load_ready, 1);
        check("post_valid", x_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        load_valid = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        nbits      = '0;
        reps       = '0;
        #12;
        check("reset_ready", load_ready, 1);
        check("reset_valid", x_valid, 0);
        check("reset_x", x, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Full-width job
        run_job(16'b1010101010100000, 5'd16, 8'd0, -1, 1'b0, -1);
        // Repeats with a short pattern, no gap between passes
        run_job(16'h002A, 5'd6, 8'd2, -1, 1'b0, -1);
        // Bit-count mapping: 0 and beyond WIDTH both mean 16
        run_job(16'hF00F, 5'd0, 8'd0, -1, 1'b0, -1);
        run_job(16'hF00F, 5'd20, 8'd0, -1, 1'b0, -1);
        // Abort at bit 5, then an immediate new job
        run_job(16'hA5C3, 5'd16, 8'd0, 5, 1'b0, -1);
        run_job(16'h1234, 5'd16, 8'd0, -1, 1'b0, -1);
        // Abort on the very last bit beats the done transition
        run_job(16'hFFFF, 5'd4, 8'd1, 7, 1'b0, -1);
        // Loads offered while busy are ignored
        run_job(16'hBEEF, 5'd16, 8'd1, -1, 1'b1, -1);
        // Mid-job asynchronous reset, then a clean job
        run_job(16'hCAFE, 5'd16, 8'd0, -1, 1'b0, 7);
        run_job(16'h0F0F, 5'd16, 8'd0, -1, 1'b0, -1);
        // Single-bit patterns
        run_job(16'h0001, 5'd1, 8'd3, -1, 1'b0, -1);
        run_job(16'hFFFE, 5'd1, 8'd2, -1, 1'b0, -1);

        // Randomized jobs
        for (int j = 0; j < 40; j++) begin
            logic [NB_W-1:0]  rnb;
            logic [REP_W-1:0] rrp;
            int               total;
            int               ab;
            int               gap;
            rnb   = NB_W'($urandom_range(0, 31));
            rrp   = REP_W'($urandom_range(0, 3));
            total = eff_n(rnb) * (int'(rrp) + 1);
            ab    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, total - 1)) : -1;
            run_job(WIDTH'($urandom), rnb, rrp, ab, 1'($urandom_range(0, 1)), -1);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("gap_ready", load_ready, 1);
                check("gap_done", done, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
